riscv_zero_decode: RTL and testbench

- Decode stage of the riscv_zero RV64I in-order pipeline, between fetch and execute.
- Contains the 32x64 integer register file, with its write port driven by writeback.
- Cracks each 32-bit instruction into its immediate, register operands and execute/memory/writeback control.
- All outputs are registered into a decode/execute pipeline register.

---
 rtl/riscv_zero_decode.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_riscv_zero_decode.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_zero_decode.sv
// riscv_zero_decode
// Decode stage of the riscv_zero RV64I in-order pipeline. Holds the 32x64
// integer register file (written by writeback) and cracks each 32-bit
// instruction into immediate, operands and execute/memory/writeback control.
// Every output is taken from the decode/execute pipeline register.

module riscv_zero_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst_data,
  input  logic [63:0] pc_in,
  input  logic        reg_wenable,
  input  logic [4:0]  reg_waddr,
  input  logic [63:0] reg_wdata,
  output logic [6:0]  opcode,
  output logic [31:0] immediate,
  output logic [4:0]  reg_dest,
  output logic [63:0] reg1_out,
  output logic [63:0] reg2_out,
  output logic [63:0] pc_out,
  output logic        writeback_enable,
  output logic [1:0]  writeback_source,
  output logic        mem_wenable,
  output logic        jump,
  output logic        branch,
  output logic        ALU_A_mux,
  output logic        ALU_B_mux,
  output logic [3:0]  ALU_OP
);

  // Major opcodes
  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_FENCE    = 7'h0F;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_OP_IMM32 = 7'h1B;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_OP32     = 7'h3B;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  // ALU operation codes shared with execute
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_SLL  = 4'h2;
  localparam logic [3:0] ALU_SLT  = 4'h3;
  localparam logic [3:0] ALU_SLTU = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_OR   = 4'h8;
  localparam logic [3:0] ALU_AND  = 4'h9;
  localparam logic [3:0] ALU_BEQ  = 4'hA;
  localparam logic [3:0] ALU_BNE  = 4'hB;
  localparam logic [3:0] ALU_BLT  = 4'hC;
  localparam logic [3:0] ALU_BGE  = 4'hD;
  localparam logic [3:0] ALU_BLTU = 4'hE;
  localparam logic [3:0] ALU_BGEU = 4'hF;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  // ---------------------------------------------------------------------
  // Immediate format helpers (all sign-extended to 32 bits)
  // ---------------------------------------------------------------------
  function automatic logic [31:0] imm_i_fn(input logic [31:0] inst);
    imm_i_fn = {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [31:0] imm_s_fn(input logic [31:0] inst);
    imm_s_fn = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  endfunction

  function automatic logic [31:0] imm_b_fn(input logic [31:0] inst);
    imm_b_fn = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j_fn(input logic [31:0] inst);
    imm_j_fn = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u_fn(input logic [31:0] inst);
    imm_u_fn = {inst[31:12], 12'h000};
  endfunction

  // Shift-immediates carry a 6-bit shamt; the funct6 bits above it are not
  // part of the value, so it is zero-extended rather than sign-extended.
  function automatic logic [31:0] imm_shamt_fn(input logic [31:0] inst);
    imm_shamt_fn = {26'd0, inst[25:20]};
  endfunction

  // Register-register ALU op: alt (inst[30]) picks SUB and SRA.
  function automatic logic [3:0] alu_op_reg_fn(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op_reg_fn = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op_reg_fn = ALU_SLL;
      3'b010:  alu_op_reg_fn = ALU_SLT;
      3'b011:  alu_op_reg_fn = ALU_SLTU;
      3'b100:  alu_op_reg_fn = ALU_XOR;
      3'b101:  alu_op_reg_fn = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op_reg_fn = ALU_OR;
      3'b111:  alu_op_reg_fn = ALU_AND;
      default: alu_op_reg_fn = ALU_ADD;
    endcase
  endfunction

  // Register-immediate ALU op: there is no SUBI, so alt only matters for SRAI.
  function automatic logic [3:0] alu_op_imm_fn(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op_imm_fn = ALU_ADD;
      3'b101:  alu_op_imm_fn = alt ? ALU_SRA : ALU_SRL;
      default: alu_op_imm_fn = alu_op_reg_fn(f3, 1'b0);
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Field extraction
  // ---------------------------------------------------------------------
  logic [6:0] opc_s;
  logic [2:0] funct3_s;
  logic       alt_s;
  logic [4:0] rd_s;
  logic [4:0] rs1_s;
  logic [4:0] rs2_s;

  assign opc_s    = inst_data[6:0];
  assign funct3_s = inst_data[14:12];
  assign alt_s    = inst_data[30];
  assign rd_s     = inst_data[11:7];
  assign rs1_s    = inst_data[19:15];
  assign rs2_s    = inst_data[24:20];

  // ---------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------
  logic [63:0] regs_r [0:31];
  logic        wr_valid_s;

  // A write to x0 is discarded; this also keeps x0 out of the bypass path.
  assign wr_valid_s = reg_wenable && (reg_waddr != 5'd0);

  // Register file storage: cleared on reset, written by writeback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 64'd0;
      end
    end else if (wr_valid_s) begin
      regs_r[reg_waddr] <= reg_wdata;
    end
  end

  logic [63:0] rs1_val_s;
  logic [63:0] rs2_val_s;

  // Operand read with same-cycle writeback bypass; x0 always reads zero.
  always_comb begin
    rs1_val_s = 64'd0;
    rs2_val_s = 64'd0;
    if (rs1_s == 5'd0) begin
      rs1_val_s = 64'd0;
    end else if (wr_valid_s && (reg_waddr == rs1_s)) begin
      rs1_val_s = reg_wdata;
    end else begin
      rs1_val_s = regs_r[rs1_s];
    end
    if (rs2_s == 5'd0) begin
      rs2_val_s = 64'd0;
    end else if (wr_valid_s && (reg_waddr == rs2_s)) begin
      rs2_val_s = reg_wdata;
    end else begin
      rs2_val_s = regs_r[rs2_s];
    end
  end

  // ---------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------
  logic [31:0] imm_s;
  logic        wb_en_s;
  logic [1:0]  wb_src_s;
  logic        mem_we_s;
  logic        jump_s;
  logic        branch_s;
  logic        a_mux_s;
  logic        b_mux_s;
  logic [3:0]  alu_op_s;
  logic        use_rs1_s;
  logic        use_rs2_s;

  // Per-opcode control; anything not listed decodes to a bubble.
  always_comb begin
    imm_s     = 32'd0;
    wb_en_s   = 1'b0;
    wb_src_s  = WB_ALU;
    mem_we_s  = 1'b0;
    jump_s    = 1'b0;
    branch_s  = 1'b0;
    a_mux_s   = 1'b0;
    b_mux_s   = 1'b0;
    alu_op_s  = ALU_ADD;
    use_rs1_s = 1'b1;
    use_rs2_s = 1'b0;
    case (opc_s)
      OPC_LUI: begin
        imm_s     = imm_u_fn(inst_data);
        b_mux_s   = 1'b1;
        wb_en_s   = 1'b1;
        use_rs1_s = 1'b0;
      end
      OPC_AUIPC: begin
        imm_s     = imm_u_fn(inst_data);
        a_mux_s   = 1'b1;
        b_mux_s   = 1'b1;
        wb_en_s   = 1'b1;
        use_rs1_s = 1'b0;
      end
      OPC_JAL: begin
        imm_s     = imm_j_fn(inst_data);
        a_mux_s   = 1'b1;
        b_mux_s   = 1'b1;
        jump_s    = 1'b1;
        wb_en_s   = 1'b1;
        wb_src_s  = WB_PC4;
        use_rs1_s = 1'b0;
      end
      OPC_JALR: begin
        imm_s    = imm_i_fn(inst_data);
        b_mux_s  = 1'b1;
        jump_s   = 1'b1;
        wb_en_s  = 1'b1;
        wb_src_s = WB_PC4;
      end
      OPC_BRANCH: begin
        imm_s     = imm_b_fn(inst_data);
        use_rs2_s = 1'b1;
        // funct3 010/011 are not branches; leave them as a bubble.
        case (funct3_s)
          3'b000:  begin branch_s = 1'b1; alu_op_s = ALU_BEQ;  end
          3'b001:  begin branch_s = 1'b1; alu_op_s = ALU_BNE;  end
          3'b100:  begin branch_s = 1'b1; alu_op_s = ALU_BLT;  end
          3'b101:  begin branch_s = 1'b1; alu_op_s = ALU_BGE;  end
          3'b110:  begin branch_s = 1'b1; alu_op_s = ALU_BLTU; end
          3'b111:  begin branch_s = 1'b1; alu_op_s = ALU_BGEU; end
          default: begin branch_s = 1'b0; alu_op_s = ALU_ADD;  end
        endcase
      end
      OPC_LOAD: begin
        imm_s    = imm_i_fn(inst_data);
        b_mux_s  = 1'b1;
        wb_en_s  = 1'b1;
        wb_src_s = WB_MEM;
      end
      OPC_STORE: begin
        imm_s     = imm_s_fn(inst_data);
        b_mux_s   = 1'b1;
        mem_we_s  = 1'b1;
        use_rs2_s = 1'b1;
      end
      OPC_OP_IMM, OPC_OP_IMM32: begin
        if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
          imm_s = imm_shamt_fn(inst_data);
        end else begin
          imm_s = imm_i_fn(inst_data);
        end
        b_mux_s  = 1'b1;
        wb_en_s  = 1'b1;
        alu_op_s = alu_op_imm_fn(funct3_s, alt_s);
      end
      OPC_OP, OPC_OP32: begin
        wb_en_s   = 1'b1;
        use_rs2_s = 1'b1;
        alu_op_s  = alu_op_reg_fn(funct3_s, alt_s);
      end
      OPC_FENCE, OPC_SYSTEM: begin
        // Handled outside the integer datapath: immediate only, no control.
        imm_s = imm_i_fn(inst_data);
      end
      default: begin
        imm_s = 32'd0;
      end
    endcase
  end

  logic [63:0] reg1_next_s;
  logic [63:0] reg2_next_s;
  logic        wb_final_s;

  assign reg1_next_s = use_rs1_s ? rs1_val_s : 64'd0;
  assign reg2_next_s = use_rs2_s ? rs2_val_s : 64'd0;
  // Writing x0 is architecturally a no-op, so never request it.
  assign wb_final_s  = wb_en_s && (rd_s != 5'd0);

  // Decode/execute pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode           <= 7'd0;
      immediate        <= 32'd0;
      reg_dest         <= 5'd0;
      reg1_out         <= 64'd0;
      reg2_out         <= 64'd0;
      pc_out           <= 64'd0;
      writeback_enable <= 1'b0;
      writeback_source <= 2'b00;
      mem_wenable      <= 1'b0;
      jump             <= 1'b0;
      branch           <= 1'b0;
      ALU_A_mux        <= 1'b0;
      ALU_B_mux        <= 1'b0;
      ALU_OP           <= 4'h0;
    end else begin
      opcode           <= opc_s;
      immediate        <= imm_s;
      reg_dest         <= rd_s;
      reg1_out         <= reg1_next_s;
      reg2_out         <= reg2_next_s;
      pc_out           <= pc_in;
      writeback_enable <= wb_final_s;
      writeback_source <= wb_src_s;
      mem_wenable      <= mem_we_s;
      jump             <= jump_s;
      branch           <= branch_s;
      ALU_A_mux        <= a_mux_s;
      ALU_B_mux        <= b_mux_s;
      ALU_OP           <= alu_op_s;
    end
  end

endmodule

// File: tb/tb_riscv_zero_decode.sv
// tb_riscv_zero_decode
// Scoreboard bench: each driven instruction pushes its expected decode,
// which is popped and compared field by field one edge later.

module tb_riscv_zero_decode;

  logic        clk;
  logic        reset;
  logic [31:0] inst_data;
  logic [63:0] pc_in;
  logic        reg_wenable;
  logic [4:0]  reg_waddr;
  logic [63:0] reg_wdata;
  logic [6:0]  opcode;
  logic [31:0] immediate;
  logic [4:0]  reg_dest;
  logic [63:0] reg1_out;
  logic [63:0] reg2_out;
  logic [63:0] pc_out;
  logic        writeback_enable;
  logic [1:0]  writeback_source;
  logic        mem_wenable;
  logic        jump;
  logic        branch;
  logic        ALU_A_mux;
  logic        ALU_B_mux;
  logic [3:0]  ALU_OP;

  riscv_zero_decode dut (
    .clk              (clk),
    .reset            (reset),
    .inst_data        (inst_data),
    .pc_in            (pc_in),
    .reg_wenable      (reg_wenable),
    .reg_waddr        (reg_waddr),
    .reg_wdata        (reg_wdata),
    .opcode           (opcode),
    .immediate        (immediate),
    .reg_dest         (reg_dest),
    .reg1_out         (reg1_out),
    .reg2_out         (reg2_out),
    .pc_out           (pc_out),
    .writeback_enable (writeback_enable),
    .writeback_source (writeback_source),
    .mem_wenable      (mem_wenable),
    .jump             (jump),
    .branch           (branch),
    .ALU_A_mux        (ALU_A_mux),
    .ALU_B_mux        (ALU_B_mux),
    .ALU_OP           (ALU_OP)
  );

  typedef struct packed {
    logic [6:0]  opc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [63:0] r1;
    logic [63:0] r2;
    logic [63:0] pc;
    logic        wb;
    logic [1:0]  src;
    logic        mw;
    logic        j;
    logic        b;
    logic        am;
    logic        bm;
    logic [3:0]  op;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic exp_t mk(input logic [6:0] opc, input logic [31:0] imm, input logic [4:0] rd,
                              input logic [63:0] r1, input logic [63:0] r2, input logic [63:0] pc,
                              input logic wb, input logic [1:0] src, input logic mw, input logic j,
                              input logic b, input logic am, input logic bm, input logic [3:0] op);
    exp_t e;
    e.opc = opc; e.imm = imm; e.rd = rd; e.r1 = r1; e.r2 = r2; e.pc = pc;
    e.wb = wb; e.src = src; e.mw = mw; e.j = j; e.b = b; e.am = am; e.bm = bm; e.op = op;
    return e;
  endfunction

  function automatic exp_t bubble(input logic [63:0] pc);
    return mk(7'h00, 32'd0, 5'd0, 64'd0, 64'd0, pc, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endfunction

  // Pop the oldest expectation and compare every output against it.
  task automatic observe(input string tag);
    exp_t e;
    e = exp_q.pop_front();
    check_val({tag, ".opcode"},    {57'd0, opcode},           {57'd0, e.opc});
    check_val({tag, ".immediate"}, {32'd0, immediate},        {32'd0, e.imm});
    check_val({tag, ".reg_dest"},  {59'd0, reg_dest},         {59'd0, e.rd});
    check_val({tag, ".reg1_out"},  reg1_out,                  e.r1);
    check_val({tag, ".reg2_out"},  reg2_out,                  e.r2);
    check_val({tag, ".pc_out"},    pc_out,                    e.pc);
    check_val({tag, ".wb_en"},     {63'd0, writeback_enable}, {63'd0, e.wb});
    check_val({tag, ".wb_src"},    {62'd0, writeback_source}, {62'd0, e.src});
    check_val({tag, ".mem_we"},    {63'd0, mem_wenable},      {63'd0, e.mw});
    check_val({tag, ".jump"},      {63'd0, jump},             {63'd0, e.j});
    check_val({tag, ".branch"},    {63'd0, branch},           {63'd0, e.b});
    check_val({tag, ".a_mux"},     {63'd0, ALU_A_mux},        {63'd0, e.am});
    check_val({tag, ".b_mux"},     {63'd0, ALU_B_mux},        {63'd0, e.bm});
    check_val({tag, ".alu_op"},    {60'd0, ALU_OP},           {60'd0, e.op});
  endtask

  // Drive one cycle of fetch + writeback input, expect the decode after the edge.
  task automatic drive(input string tag, input logic [31:0] inst, input logic [63:0] pc,
                       input logic we, input logic [4:0] wa, input logic [63:0] wd, input exp_t e);
    @(negedge clk);
    inst_data   = inst;
    pc_in       = pc;
    reg_wenable = we;
    reg_waddr   = wa;
    reg_wdata   = wd;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    observe(tag);
  endtask

  initial begin
    reset       = 1'b1;
    inst_data   = 32'd0;
    pc_in       = 64'd0;
    reg_wenable = 1'b0;
    reg_waddr   = 5'd0;
    reg_wdata   = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(bubble(64'd0));
    observe("reset");
    @(negedge clk);
    reset = 1'b0;

    // addi x1,x0,5
    drive("addi", 32'h00500093, 64'h0, 1'b0, 5'd0, 64'd0,
          mk(7'h13, 32'd5, 5'd1, 64'd0, 64'd0, 64'h0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0));
    // Register writes during bubbles
    drive("wr_x3", 32'h00000000, 64'h4, 1'b1, 5'd3, 64'hDEADBEEF00000001, bubble(64'h4));
    drive("wr_x1", 32'h00000000, 64'h8, 1'b1, 5'd1, 64'h0000000000001000, bubble(64'h8));
    drive("wr_x2", 32'h00000000, 64'hC, 1'b1, 5'd2, 64'h0000000000000055, bubble(64'hC));
    // add x4,x3,x0 reading stored x3
    drive("add_rd", 32'h00018233, 64'h10, 1'b0, 5'd0, 64'd0,
          mk(7'h33, 32'd0, 5'd4, 64'hDEADBEEF00000001, 64'd0, 64'h10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0));
    // Same instruction with x3 written in the same cycle: bypass
    drive("add_byp", 32'h00018233, 64'h14, 1'b1, 5'd3, 64'h1122334455667788,
          mk(7'h33, 32'd0, 5'd4, 64'h1122334455667788, 64'd0, 64'h14, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0));
    drive("add_new", 32'h00018233, 64'h18, 1'b0, 5'd0, 64'd0,
          mk(7'h33, 32'd0, 5'd4, 64'h1122334455667788, 64'd0, 64'h18, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0));
    // add x4,x0,x0 while writing x0: must read 0, then still 0
    drive("x0_wr", 32'h00000233, 64'h1C, 1'b1, 5'd0, 64'hFFFFFFFFFFFFFFFF,
          mk(7'h33, 32'd0, 5'd4, 64'd0, 64'd0, 64'h1C, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0));
    drive("x0_rd", 32'h00000233, 64'h20, 1'b0, 5'd0, 64'd0,
          mk(7'h33, 32'd0, 5'd4, 64'd0, 64'd0, 64'h20, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0));
    // sw x2,8(x1)
    drive("sw", 32'h0020A423, 64'h24, 1'b0, 5'd0, 64'd0,
          mk(7'h23, 32'd8, 5'd8, 64'h1000, 64'h55, 64'h24, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0));
    // beq x1,x2,-8
    drive("beq", 32'hFE208CE3, 64'h28, 1'b0, 5'd0, 64'd0,
          mk(7'h63, 32'hFFFFFFF8, 5'd25, 64'h1000, 64'h55, 64'h28, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hA));
    // sub x7,x1,x2
    drive("sub", 32'h402083B3, 64'h2C, 1'b0, 5'd0, 64'd0,
          mk(7'h33, 32'd0, 5'd7, 64'h1000, 64'h55, 64'h2C, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1));
    // lw x5,4(x1)
    drive("lw", 32'h0040A283, 64'h30, 1'b0, 5'd0, 64'd0,
          mk(7'h03, 32'd4, 5'd5, 64'h1000, 64'd0, 64'h30, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0));
    // lui x5,0x12345
    drive("lui", 32'h123452B7, 64'h34, 1'b0, 5'd0, 64'd0,
          mk(7'h37, 32'h12345000, 5'd5, 64'd0, 64'd0, 64'h34, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0));
    // jal x1,16 at pc 0x40
    drive("jal", 32'h010000EF, 64'h40, 1'b0, 5'd0, 64'd0,
          mk(7'h6F, 32'd16, 5'd1, 64'd0, 64'd0, 64'h40, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0));
    // srai x6,x6,3 with x6 bypassed from writeback
    drive("srai", 32'h40335313, 64'h44, 1'b1, 5'd6, 64'h00000000000000F0,
          mk(7'h13, 32'd3, 5'd6, 64'hF0, 64'd0, 64'h44, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h7));
    // Unknown opcode: bubble
    drive("unknown", 32'h00000000, 64'h48, 1'b0, 5'd0, 64'd0, bubble(64'h48));
    // nop (addi x0,x0,0): writeback suppressed for rd=0
    drive("nop", 32'h00000013, 64'h4C, 1'b0, 5'd0, 64'd0,
          mk(7'h13, 32'd0, 5'd0, 64'd0, 64'd0, 64'h4C, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0));
    drive("pre_rst", 32'h00500093, 64'h50, 1'b0, 5'd0, 64'd0,
          mk(7'h13, 32'd5, 5'd1, 64'd0, 64'd0, 64'h50, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0));

    // Mid-stream reset between edges: outputs clear without waiting for a clock
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back(bubble(64'd0));
    observe("mid_reset");
    @(negedge clk);
    reset = 1'b0;

    // Registers cleared by reset
    drive("post_x3", 32'h00018233, 64'h54, 1'b0, 5'd0, 64'd0,
          mk(7'h33, 32'd0, 5'd4, 64'd0, 64'd0, 64'h54, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0));
    drive("post_sw", 32'h0020A423, 64'h58, 1'b0, 5'd0, 64'd0,
          mk(7'h23, 32'd8, 5'd8, 64'd0, 64'd0, 64'h58, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
